// File: rtl/word_pkg.sv
// Shared widths and FSM state type for the word/byte conversion blocks.
package word_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int CNT_W          = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/word_byte_select.sv
// Combinational 4:1 byte-lane mux; idx counts emitted bytes, MSB_FIRST picks lane order.
module word_byte_select
    import word_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic [WORD_W-1:0] word,
    input  logic [CNT_W-1:0]  idx,
    output logic [BYTE_W-1:0] lane_byte
);

    logic [CNT_W-1:0] lane;

    // With four lanes, reversing the order is just the bitwise complement of idx.
    assign lane = (MSB_FIRST != 0) ? ~idx : idx;

    always_comb begin
        lane_byte = '0;
        case (lane)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            2'd3:    lane_byte = word[31:24];
            default: lane_byte = '0;
        endcase
    end

endmodule

// File: rtl/word_byte_unpacker.sv
// Splits 32-bit words into four bytes over valid/ready handshakes with zero-bubble reload.
// Build option: define UNPACKER_PARITY_EN to add the even-parity output m_parity.
module word_byte_unpacker
    import word_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
`ifdef UNPACKER_PARITY_EN
    ,
    output logic              m_parity
`endif
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              armed_q;
    logic [BYTE_W-1:0] lane_byte;

    // armed_q keeps s_ready low while reset is held and until the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            hold_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready = armed_q;
                if (s_valid && armed_q) begin
                    hold_d  = s_data;
                    count_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_last  = (count_q == CNT_W'(BYTES_PER_WORD - 1));
                if (m_ready) begin
                    if (m_last) begin
                        s_ready = 1'b1;
                        count_d = '0;
                        if (s_valid) begin
                            hold_d = s_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    word_byte_select #(
        .MSB_FIRST (MSB_FIRST)
    ) u_select (
        .word      (hold_q),
        .idx       (count_q),
        .lane_byte (lane_byte)
    );

    assign m_data = m_valid ? lane_byte : '0;
    assign busy   = (state_q == SEND);

`ifdef UNPACKER_PARITY_EN
    assign m_parity = m_valid & (^m_data);
`endif

endmodule

// File: tb/tb_word_byte_unpacker.sv
// Bench for word_byte_unpacker: little- and big-endian instances share stimulus and are
// checked against a byte-queue reference model.
module tb_word_byte_unpacker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_valid;
    logic [31:0] s_data;
    logic        m_ready;
    logic        s_ready0, m_valid0, m_last0, busy0;
    logic        s_ready1, m_valid1, m_last1, busy1;
    logic [7:0]  m_data0, m_data1;
`ifdef UNPACKER_PARITY_EN
    logic        m_parity0, m_parity1;
`endif

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic [7:0] le;
        logic [7:0] be;
        logic       last;
    } ent_t;
    ent_t q[$];

    logic       exp_valid, exp_last, exp_sready, exp_busy;
    logic [7:0] exp_le, exp_be;

    always #5 clk = ~clk;

    word_byte_unpacker #(.MSB_FIRST(0)) dut_le (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0), .busy(busy0)
`ifdef UNPACKER_PARITY_EN
        , .m_parity(m_parity0)
`endif
    );

    word_byte_unpacker #(.MSB_FIRST(1)) dut_be (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1), .busy(busy1)
`ifdef UNPACKER_PARITY_EN
        , .m_parity(m_parity1)
`endif
    );

    // Drive inputs away from the clock edge and derive expected outputs from the byte queue.
    task automatic drive(input logic sv, input logic [31:0] sd, input logic mr);
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        exp_valid  = (q.size() != 0);
        exp_le     = exp_valid ? q[0].le : 8'h00;
        exp_be     = exp_valid ? q[0].be : 8'h00;
        exp_last   = exp_valid ? q[0].last : 1'b0;
        exp_sready = (q.size() == 0) || (q.size() == 1 && mr);
        exp_busy   = exp_valid;
    endtask

    task automatic advance();
        logic [31:0] w;
        w = s_data;
        @(posedge clk);
        if (exp_valid && m_ready) void'(q.pop_front());
        if (s_valid && exp_sready) begin
            for (int i = 0; i < 4; i++) begin
                ent_t e;
                e.le   = w[8*i +: 8];
                e.be   = w[8*(3-i) +: 8];
                e.last = (i == 3);
                q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        #3;
        vectors++;
        if ({m_valid0, m_last0, s_ready0, busy0, m_data0} !== 12'h000) begin
            fails++;
            $display("FAIL reset_le: got v=%b l=%b r=%b b=%b d=%h want all 0", m_valid0, m_last0, s_ready0, busy0, m_data0);
        end
        vectors++;
        if ({m_valid1, m_last1, s_ready1, busy1, m_data1} !== 12'h000) begin
            fails++;
            $display("FAIL reset_be: got v=%b l=%b r=%b b=%b d=%h want all 0", m_valid1, m_last1, s_ready1, busy1, m_data1);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        vectors++;
        if ({s_ready0, s_ready1, m_data0, m_data1} !== {1'b1, 1'b1, 16'h0000}) begin
            fails++;
            $display("FAIL post_reset: got s_ready=%b%b data=%h/%h want 11 00/00", s_ready0, s_ready1, m_data0, m_data1);
        end
        advance();
    endtask

    task automatic test_single_word();
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 32'h44332211, 1'b1);
            vectors += 4;
            if (m_data0 !== exp_le) begin fails++; $display("FAIL single_data_le c%0d: got %h want %h", c, m_data0, exp_le); end
            if (m_data1 !== exp_be) begin fails++; $display("FAIL single_data_be c%0d: got %h want %h", c, m_data1, exp_be); end
            if ({m_valid0, m_last0, s_ready0, busy0} !== {exp_valid, exp_last, exp_sready, exp_busy}) begin
                fails++; $display("FAIL single_ctrl_le c%0d: got %b want %b", c, {m_valid0, m_last0, s_ready0, busy0}, {exp_valid, exp_last, exp_sready, exp_busy});
            end
            if ({m_valid1, m_last1, s_ready1, busy1} !== {exp_valid, exp_last, exp_sready, exp_busy}) begin
                fails++; $display("FAIL single_ctrl_be c%0d: got %b want %b", c, {m_valid1, m_last1, s_ready1, busy1}, {exp_valid, exp_last, exp_sready, exp_busy});
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic mr_seq [0:9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 10; c++) begin
            drive(c == 0, 32'h44332211, mr_seq[c]);
            vectors += 4;
            if (m_data0 !== exp_le) begin fails++; $display("FAIL bp_data_le c%0d: got %h want %h", c, m_data0, exp_le); end
            if (m_data1 !== exp_be) begin fails++; $display("FAIL bp_data_be c%0d: got %h want %h", c, m_data1, exp_be); end
            if ({m_valid0, m_last0, s_ready0, busy0} !== {exp_valid, exp_last, exp_sready, exp_busy}) begin
                fails++; $display("FAIL bp_ctrl_le c%0d: got %b want %b", c, {m_valid0, m_last0, s_ready0, busy0}, {exp_valid, exp_last, exp_sready, exp_busy});
            end
            if ({m_valid1, m_last1, s_ready1, busy1} !== {exp_valid, exp_last, exp_sready, exp_busy}) begin
                fails++; $display("FAIL bp_ctrl_be c%0d: got %b want %b", c, {m_valid1, m_last1, s_ready1, busy1}, {exp_valid, exp_last, exp_sready, exp_busy});
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 11; c++) begin
            drive(c < 5, (c == 0) ? 32'hAABBCCDD : 32'h01020304, 1'b1);
            vectors += 4;
            if (m_data0 !== exp_le) begin fails++; $display("FAIL b2b_data_le c%0d: got %h want %h", c, m_data0, exp_le); end
            if (m_data1 !== exp_be) begin fails++; $display("FAIL b2b_data_be c%0d: got %h want %h", c, m_data1, exp_be); end
            if ({m_valid0, m_last0, s_ready0, busy0} !== {exp_valid, exp_last, exp_sready, exp_busy}) begin
                fails++; $display("FAIL b2b_ctrl_le c%0d: got %b want %b", c, {m_valid0, m_last0, s_ready0, busy0}, {exp_valid, exp_last, exp_sready, exp_busy});
            end
            if ({m_valid1, m_last1, s_ready1, busy1} !== {exp_valid, exp_last, exp_sready, exp_busy}) begin
                fails++; $display("FAIL b2b_ctrl_be c%0d: got %b want %b", c, {m_valid1, m_last1, s_ready1, busy1}, {exp_valid, exp_last, exp_sready, exp_busy});
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'hDEADBEEF, 1'b1);
        advance();
        drive(1'b0, 32'h0, 1'b1);
        vectors++;
        if (m_data0 !== 8'hEF) begin fails++; $display("FAIL ar_first_byte: got %h want ef", m_data0); end
        advance();
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        vectors += 2;
        if ({m_valid0, busy0, m_last0, s_ready0, m_data0} !== 12'h000) begin
            fails++; $display("FAIL ar_async_le: got v=%b b=%b l=%b r=%b d=%h want all 0", m_valid0, busy0, m_last0, s_ready0, m_data0);
        end
        if ({m_valid1, busy1, m_last1, s_ready1, m_data1} !== 12'h000) begin
            fails++; $display("FAIL ar_async_be: got v=%b b=%b l=%b r=%b d=%h want all 0", m_valid1, busy1, m_last1, s_ready1, m_data1);
        end
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 32'h0, 1'b1);
            vectors++;
            if ({m_valid0, m_valid1, s_ready0, s_ready1, m_data0, m_data1} !== {exp_valid, exp_valid, exp_sready, exp_sready, exp_le, exp_be}) begin
                fails++; $display("FAIL ar_stale c%0d: got v=%b%b r=%b%b d=%h/%h want v=00 r=11 d=00/00", c, m_valid0, m_valid1, s_ready0, s_ready1, m_data0, m_data1);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 1) == 1), $urandom(), ($urandom_range(0, 9) < 7));
            vectors += 4;
            if (m_data0 !== exp_le) begin fails++; $display("FAIL rnd_data_le c%0d: got %h want %h", c, m_data0, exp_le); end
            if (m_data1 !== exp_be) begin fails++; $display("FAIL rnd_data_be c%0d: got %h want %h", c, m_data1, exp_be); end
            if ({m_valid0, m_last0, s_ready0, busy0} !== {exp_valid, exp_last, exp_sready, exp_busy}) begin
                fails++; $display("FAIL rnd_ctrl_le c%0d: got %b want %b", c, {m_valid0, m_last0, s_ready0, busy0}, {exp_valid, exp_last, exp_sready, exp_busy});
            end
            if ({m_valid1, m_last1, s_ready1, busy1} !== {exp_valid, exp_last, exp_sready, exp_busy}) begin
                fails++; $display("FAIL rnd_ctrl_be c%0d: got %b want %b", c, {m_valid1, m_last1, s_ready1, busy1}, {exp_valid, exp_last, exp_sready, exp_busy});
            end
            advance();
        end
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 32'h0, 1'b1);
            advance();
        end
    endtask

`ifdef UNPACKER_PARITY_EN
    task automatic test_parity();
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 32'h00000307, 1'b1);
            vectors += 2;
            if (m_parity0 !== (exp_valid & (^exp_le))) begin
                fails++; $display("FAIL parity_le c%0d: got %b want %b", c, m_parity0, exp_valid & (^exp_le));
            end
            if (m_parity1 !== (exp_valid & (^exp_be))) begin
                fails++; $display("FAIL parity_be c%0d: got %b want %b", c, m_parity1, exp_valid & (^exp_be));
            end
            advance();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef UNPACKER_PARITY_EN
        test_parity();
`endif
        do_reset();
        drive(1'b0, 32'h0, 1'b1);
        vectors++;
        if ({m_valid0, busy0, s_ready0} !== 3'b001) begin
            fails++; $display("FAIL final_idle: got v=%b b=%b r=%b want 0 0 1", m_valid0, busy0, s_ready0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/word_byte_unpacker.md
Name: word_byte_unpacker

Overview:
- Transmit-side counterpart of the team's 32-bit word registers.
- Accepts one 32-bit word over a valid/ready input handshake, holds it in an internal 32-bit register, and emits it as four 8-bit bytes over a valid/ready output handshake.
- Sits between word-wide datapath registers and byte-wide consumers (UART TX, byte bus).

Parameters:
- MSB_FIRST, 0, 0 = emit byte lane [7:0] first (little-endian); 1 = emit [31:24] first.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  block can accept a word this cycle.
- s_data  input  32  input word.
- m_valid  output  1  output byte valid.
- m_ready  input  1  downstream accepts byte this cycle.
- m_data  output  8  current output byte.
- m_last  output  1  current byte is the 4th byte of the word.
- busy  output  1  word held, not yet fully emitted.

Behaviour:
- Single clock clk; reset_n is asynchronous, active-low. Assertion immediately forces: state=IDLE, hold register=0, byte count=0, m_valid=0, m_last=0, busy=0, s_ready=0 while reset_n is low.
- After reset release, outputs are m_data=0x00 and s_ready=1.
- FSM states:
  - IDLE: s_ready=1, m_valid=0. If s_valid, capture s_data into the hold register, set count=0, go to SEND.
  - SEND: m_valid=1. m_data = byte lane selected by count and MSB_FIRST. m_last=1 when count==3.
    - Byte accepted when m_valid && m_ready: count increments.
    - Accepted byte with count==3 ends the word: return to IDLE, or reload (below).
- Zero-bubble reload: in SEND, s_ready=1 only when count==3 && m_ready. If s_valid also, the new word is captured in the same edge, count=0, and the FSM stays in SEND. Result: continuous stream of 4 bytes per 4 cycles.
- Latency: word captured at edge N; first byte is valid from cycle N+1. With m_ready held high, the last byte completes at edge N+4.
- Backpressure: while m_valid && !m_ready, m_data, m_last and count are held stable. Input words are never dropped or overwritten mid-word.
- busy = (state==SEND).
- Count is 2 bits and wraps 3→0 only on word completion.
- Reset mid-word: the partial word is discarded; no further bytes are emitted.
- s_data is ignored whenever s_ready=0.

Optional Feature:
- Macro UNPACKER_PARITY_EN.
- Defined: adds output m_parity (1 bit) = XOR of m_data bits (even parity), valid whenever m_valid=1, 0 in reset/IDLE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package word_pkg:
  - BYTES_PER_WORD=4, WORD_W=32, BYTE_W=8, CNT_W=2.
  - State typedef with states IDLE and SEND.
- One sub-module: word_byte_select. Combinational 4:1 byte-lane mux with inputs word[31:0], idx[1:0], MSB_FIRST parameter; output byte[7:0].
- Top level owns the FSM, count and hold register.

Test Plan:
- Reset then word 0x44332211 with MSB_FIRST=0 and m_ready=1 → m_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles; m_last only on 0x44; then IDLE, s_ready=1.
- Same word with MSB_FIRST=1 → 0x44,0x33,0x22,0x11; m_last on 0x11.
- Backpressure: m_ready low for 3 cycles during byte 2 → m_data holds 0x22 stable, m_valid stays 1; resumes 0x33 after m_ready rises.
- Back-to-back: words 0xAABBCCDD then 0x01020304 with s_valid always high and m_ready=1 → 8 contiguous valid bytes DD,CC,BB,AA,04,03,02,01; s_ready pulses only on the last byte of each word.
- Async reset asserted after byte 1 of 0xDEADBEEF → m_valid=0, busy=0 immediately without a clock edge; after release s_ready=1, m_data=0x00, and no stale bytes appear.
- With UNPACKER_PARITY_EN: byte 0x07 → m_parity=1; byte 0x03 → m_parity=0.
